// File: rtl/dtree_pkg.sv
// Shared types and helpers for the decision-tree feeder.
// Holds the FSM state enum, the LW width helper and the timeout result.
package dtree_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_HOLD
  } feeder_state_t;

  // max(1, clog2(n)): width of level/path and of the feature index
  function automatic int lw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // result reported when the tree never answers
  localparam logic [31:0] TIMEOUT_RESULT = '1;

endpackage

// File: rtl/dtree_feeder_watchdog.sv
// WAIT-state watchdog: counts cycles while run is high.
// Ports: clk, rst_n, run (in WAIT), expired (last allowed WAIT cycle).
module dtree_feeder_watchdog
  import dtree_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int CW = lw_of(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dtree_feeder.sv
// Serializes a feature vector into dtree and returns its verdict.
// Ports: frame_* (upstream), tx_* (tree sample), tree_* (verdict),
// class_* (result out), protocol_err (sticky). Watchdog: DTREE_FEEDER_WATCHDOG_EN.
module dtree_feeder
  import dtree_pkg::*;
#(
  parameter int FEATURES       = 3,
  parameter int IN_WIDTH       = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic [FEATURES*IN_WIDTH-1:0] frame,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [IN_WIDTH-1:0]          tx_sample,
  input  logic [lw_of(FEATURES)-1:0]   tree_level,
  input  logic [lw_of(FEATURES)-1:0]   tree_path,
  input  logic                         tree_valid,
  output logic                         class_valid,
  input  logic                         class_ready,
  output logic [lw_of(FEATURES)-1:0]   class_level,
  output logic [lw_of(FEATURES)-1:0]   class_path,
  output logic                         protocol_err
);

  localparam int LW = lw_of(FEATURES);
  localparam int IW = lw_of(FEATURES);

  feeder_state_t state_q, state_d;

  logic [IN_WIDTH-1:0] vec_q [FEATURES];
  logic [IN_WIDTH-1:0] vec_d [FEATURES];
  logic [IW-1:0]       idx_q, idx_d;
  logic                frame_ready_q, frame_ready_d;
  logic                tx_valid_q, tx_valid_d;
  logic [IN_WIDTH-1:0] tx_sample_q, tx_sample_d;
  logic                class_valid_q, class_valid_d;
  logic [LW-1:0]       level_q, level_d;
  logic [LW-1:0]       path_q, path_d;
  logic                err_q, err_d;
  logic                wd_run;
  logic                wd_expired;

  assign wd_run = (state_q == S_WAIT);

`ifdef DTREE_FEEDER_WATCHDOG_EN
  dtree_feeder_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst_n  (reset),
    .run    (wd_run),
    .expired(wd_expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_wd_run;
  assign unused_wd_run = wd_run;
  assign wd_expired = 1'b0;
`endif

  assign frame_ready  = frame_ready_q;
  assign tx_valid     = tx_valid_q;
  assign tx_sample    = tx_sample_q;
  assign class_valid  = class_valid_q;
  assign class_level  = level_q;
  assign class_path   = path_q;
  assign protocol_err = err_q;

  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    idx_d         = idx_q;
    tx_valid_d    = tx_valid_q;
    tx_sample_d   = tx_sample_q;
    class_valid_d = class_valid_q;
    level_d       = level_q;
    path_d        = path_q;
    // a verdict is only legal while waiting for one
    err_d         = err_q | (tree_valid && (state_q != S_WAIT));

    unique case (state_q)
      S_IDLE: begin
        if (frame_valid && frame_ready_q) begin
          for (int k = 0; k < FEATURES; k++) begin
            vec_d[k] = frame[k*IN_WIDTH +: IN_WIDTH];
          end
          idx_d       = '0;
          tx_valid_d  = 1'b1;
          tx_sample_d = frame[IN_WIDTH-1:0];
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == IW'(FEATURES - 1)) begin
            tx_valid_d = 1'b0;
            state_d    = S_WAIT;
          end else begin
            idx_d       = idx_q + 1'b1;
            tx_sample_d = vec_q[idx_d];
          end
        end
      end
      S_WAIT: begin
        // a real verdict beats a same-edge expiry
        if (tree_valid) begin
          level_d       = tree_level;
          path_d        = tree_path;
          class_valid_d = 1'b1;
          state_d       = S_HOLD;
        end else if (wd_expired) begin
          level_d       = TIMEOUT_RESULT[LW-1:0];
          path_d        = TIMEOUT_RESULT[LW-1:0];
          err_d         = 1'b1;
          class_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (class_ready) begin
          class_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ready only from the cycle after a result handshake
    frame_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      for (int k = 0; k < FEATURES; k++) begin
        vec_q[k] <= '0;
      end
      idx_q         <= '0;
      frame_ready_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_sample_q   <= '0;
      class_valid_q <= 1'b0;
      level_q       <= '0;
      path_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_q         <= vec_d;
      idx_q         <= idx_d;
      frame_ready_q <= frame_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_sample_q   <= tx_sample_d;
      class_valid_q <= class_valid_d;
      level_q       <= level_d;
      path_q        <= path_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: doc/dtree_feeder.md
# dtree_feeder

Transmit-side companion to the decision-tree classifier. The block accepts one complete feature vector per spike event, serializes it onto the classifier's sample interface (`in_valid`/`ready`/`sample`), then waits for the tree's `level`/`path`/`out_valid` verdict and returns that result to the upstream requester under a valid/ready handshake. It sits between the feature-extraction stage and `dtree`, and it owns the transaction ordering of both ends.

## Interface
- `FEATURES`, 3: samples per vector; must equal the tree's `FEATURES`.
- `IN_WIDTH`, 10: bits per feature, two's complement.
- `TIMEOUT_CYCLES`, 64: WAIT-state watchdog limit; used only when the watchdog macro is defined.
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low; low = reset.
- `frame_valid`  input  1  upstream vector valid.
- `frame_ready`  output  1  block can accept a vector.
- `frame`  input  FEATURES*IN_WIDTH  feature k at bits [k*IN_WIDTH +: IN_WIDTH].
- `tx_valid`  output  1  drives tree `in_valid`.
- `tx_ready`  input  1  from tree `ready`.
- `tx_sample`  output  IN_WIDTH  drives tree `sample`.
- `tree_level`, `tree_path`  input  LW each  from tree; LW = max(1, $clog2(FEATURES)).
- `tree_valid`  input  1  from tree `out_valid`.
- `class_valid`  output  1  result valid.
- `class_ready`  input  1  downstream accepts result.
- `class_level`, `class_path`  output  LW each  registered result.
- `protocol_err`  output  1  sticky flag; cleared only by reset.

## Operation
- FSM states: IDLE, SEND, WAIT, HOLD. Reset state is IDLE.
- IDLE: `frame_ready`=1. If `frame_valid`, capture `frame` into the vector buffer, clear the feature index to 0, and go to SEND.
- SEND: `tx_valid`=1 and `tx_sample` = buffer[index]; both are registered. A transfer happens on each edge where `tx_valid`&&`tx_ready`. On a transfer the index increments. The transfer at index FEATURES-1 moves the FSM to WAIT and drops `tx_valid`. If `tx_ready` is low, `tx_valid` and `tx_sample` hold their values.
- WAIT: on `tree_valid`, capture `tree_level`/`tree_path` and go to HOLD.
- HOLD: `class_valid`=1. On `class_valid`&&`class_ready`, go to IDLE.
- `tree_valid` in IDLE, SEND or HOLD is ignored and sets `protocol_err`.
- `frame_valid` outside IDLE is ignored; upstream holds the vector.
- Index width is $clog2(FEATURES). It never wraps past FEATURES-1 and is reset to 0 on each accept.

## Timing
- Reset values: `frame_ready`=0 while `reset` is low and 1 after release; `tx_valid`=0, `tx_sample`=0, `class_valid`=0, `class_level`=0, `class_path`=0, `protocol_err`=0.
- Reset asserted mid-operation drops all outputs immediately and discards the buffer and any pending result.
- Accept on edge 0 → `tx_valid` high from cycle 1. With `tx_ready` held high, features 0..FEATURES-1 appear on cycles 1..FEATURES and WAIT begins on cycle FEATURES+1.
- `tree_valid` sampled on edge n → `class_valid` high from cycle n+1.
- A HOLD→IDLE handshake and a new `frame_valid` cannot overlap. The next accept happens no earlier than the cycle after the result handshake.
- Minimum frame-to-frame period is FEATURES + tree latency + 3 cycles.

## Configuration
- `DTREE_FEEDER_WATCHDOG_EN` defined:
  - A counter runs in WAIT.
  - After TIMEOUT_CYCLES cycles without `tree_valid`, the FSM goes to HOLD with `class_level`=`class_path`=all-ones and sets `protocol_err`.
  - A `tree_valid` on the same edge as expiry wins: the real result is captured and no error is flagged.
- `DTREE_FEEDER_WATCHDOG_EN` undefined:
  - No counter and no `TIMEOUT_CYCLES` logic are built.
  - WAIT lasts indefinitely.

## Structure
- Shared package `dtree_pkg`:
  - state enum `feeder_state_t` (IDLE/SEND/WAIT/HOLD);
  - the LW width function;
  - the all-ones timeout result constant.
- One sub-module, `dtree_feeder_watchdog`: the WAIT counter and expiry flag, instantiated only under the macro.
- Vector buffer, serializer and FSM stay in the top level.

## Test plan
- Basic transfer: FEATURES=3, IN_WIDTH=10, `frame` with features {0x005, 0x200, 0x3FF}, `tx_ready`=1 → `tx_sample` = 0x005, 0x200, 0x3FF on cycles 1-3. `tree_valid` with level=2, path=1 → `class_valid` on the next cycle with 2/1.
- Backpressure: `tx_ready` low for 4 cycles after feature 0 → `tx_sample` holds 0x200 with `tx_valid`=1, and there are no duplicate or skipped transfers.
- Result stall: `class_ready` low for 5 cycles → `class_valid` and the result stay stable, and `frame_ready` stays 0 until the handshake.
- Spurious result: `tree_valid` pulse during SEND → `protocol_err`=1, the FSM continues sending, and the later real result is still delivered.
- Mid-operation reset: `reset` low during SEND at index 1 → `tx_valid`=0 asynchronously. After release the block is in IDLE, and the next frame starts at feature 0.
- Watchdog (macro defined, TIMEOUT_CYCLES=8): no `tree_valid` → HOLD on the 8th WAIT cycle with level=path=all-ones and `protocol_err`=1.
